// File: rtl/alu_md.sv
// rtl/alu_md.sv - ALU with registered result, valid/ready handshake and iterative mul/div into HI/LO
// Single-cycle ops finish one edge after accept; MULT/DIV run PREP -> ITER(WIDTH) -> FIX.
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_a, r_b, r_m;
  logic [2*WIDTH-1:0]     r_p;
  logic                   r_is_div, r_signed, r_neg_q, r_neg_r, r_b_zero;
  logic [WIDTH-1:0]       r_result, r_hi, r_lo;
  logic                   r_out_valid, r_ovf;

  logic                   w_accept, w_is_md, w_add_ovf;
  logic [WIDTH-1:0]       w_sum, w_alu, w_mag_a, w_mag_b;
  logic [WIDTH:0]         w_mul_sum, w_div_sh;
  logic [2*WIDTH-1:0]     w_mul_p, w_div_p, w_prod;
  logic                   w_div_ge;
  logic [WIDTH-1:0]       w_div_rem, w_quo, w_rem;

  assign in_ready  = (r_state == S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_is_md   = (op >= 4'd10) && (op <= 4'd13);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign hi        = r_hi;
  assign lo        = r_lo;

  assign w_sum     = a + b;
  assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    w_alu = '0;
    case (op)
      4'd0, 4'd1: w_alu = w_sum;
      4'd2:       w_alu = a - b;
      4'd3:       w_alu = a & b;
      4'd4:       w_alu = a | b;
      4'd5:       w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd6:       w_alu = {b[HW-1:0], {HW{1'b0}}};
      4'd7:       w_alu = a ^ b;
      4'd8:       w_alu = ~(a | b);
      4'd9:       w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd14:      w_alu = r_hi;
      4'd15:      w_alu = r_lo;
      default:    w_alu = '0;
    endcase
  end

  // Operands are reduced to magnitudes so one unsigned engine serves both signednesses.
  assign w_mag_a = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_mag_b = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  // Multiply: r_p = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
  assign w_mul_p   = r_p[0] ? {w_mul_sum, r_p[WIDTH-1:1]} : {1'b0, r_p[2*WIDTH-1:1]};

  // Divide: r_p = {partial remainder, dividend/quotient bits}, shifted left each step.
  assign w_div_sh  = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_div_ge  = w_div_sh >= {1'b0, r_m};
  assign w_div_rem = w_div_sh[WIDTH-1:0] - r_m;
  assign w_div_p   = w_div_ge ? {w_div_rem, r_p[WIDTH-2:0], 1'b1}
                              : {w_div_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};

  assign w_prod = r_neg_q ? -r_p : r_p;
  assign w_quo  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_md) w_state_nxt = S_PREP;
      S_PREP: w_state_nxt = S_ITER;
      S_ITER: if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_m         <= '0;
      r_p         <= '0;
      r_is_div    <= 1'b0;
      r_signed    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_b_zero    <= 1'b0;
      r_result    <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_md) begin
              r_a      <= a;
              r_b      <= b;
              r_is_div <= op[2];
              r_signed <= ~op[0];
            end else begin
              r_result    <= w_alu;
              r_ovf       <= (op == 4'd0) && w_add_ovf;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_PREP: begin
          r_p      <= {{WIDTH{1'b0}}, w_mag_a};
          r_m      <= w_mag_b;
          r_neg_q  <= r_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r  <= r_signed && r_a[WIDTH-1];
          r_b_zero <= (r_b == '0);
          r_cnt    <= CW'(WIDTH);
        end
        S_ITER: begin
          r_p   <= r_is_div ? w_div_p : w_mul_p;
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          if (r_is_div && r_b_zero) begin
            r_hi     <= r_a;
            r_lo     <= '1;
            r_result <= '1;
          end else if (r_is_div) begin
            r_hi     <= w_rem;
            r_lo     <= w_quo;
            r_result <= w_quo;
          end else begin
            r_hi     <= w_prod[2*WIDTH-1:WIDTH];
            r_lo     <= w_prod[WIDTH-1:0];
            r_result <= w_prod[WIDTH-1:0];
          end
          r_ovf       <= 1'b0;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - directed table-driven bench for alu_md at WIDTH=32 and WIDTH=8
module tb_alu_md;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, ovf;
  logic [3:0]  op;
  logic [31:0] a, b, result, hi, lo;
  logic        in_valid_8, in_ready_8, out_valid_8, ovf_8;
  logic [3:0]  op_8;
  logic [7:0]  a_8, b_8, result_8, hi_8, lo_8;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .result(result), .ovf(ovf), .hi(hi), .lo(lo)
  );

  alu_md #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8), .op(op_8),
    .a(a_8), .b(b_8), .out_valid(out_valid_8), .result(result_8), .ovf(ovf_8), .hi(hi_8), .lo(lo_8)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic do_single(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                           input logic [31:0] eres, input string nm);
    in_valid = 1'b1; op = o; a = xa; b = xb;
    tick();
    in_valid = 1'b0;
    chk({nm, " valid"}, 64'(out_valid), 64'd1);
    chk({nm, " result"}, 64'(result), 64'(eres));
  endtask

  task automatic run_md(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] ohi, input logic [31:0] olo,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int   k;
    logic ok;
    in_valid = 1'b1; op = o; a = xa; b = xb;
    tick();
    in_valid = 1'b0;
    k  = 0;
    ok = 1'b1;
    while (out_valid !== 1'b1 && k < 100) begin
      if (in_ready !== 1'b0 || hi !== ohi || lo !== olo) ok = 1'b0;
      // A request during busy must be ignored.
      if (k == 5) begin in_valid = 1'b1; op = 4'd1; a = 32'd1; b = 32'd1; end
      else in_valid = 1'b0;
      tick();
      k++;
    end
    in_valid = 1'b0;
    chk({nm, " latency"}, 64'(k), 64'd34);
    chk({nm, " busy ready/hold"}, 64'(ok), 64'd1);
    chk({nm, " hi"}, 64'(hi), 64'(ehi));
    chk({nm, " lo"}, 64'(lo), 64'(elo));
    chk({nm, " result"}, 64'(result), 64'(elo));
    chk({nm, " ready at done"}, 64'(in_ready), 64'd1);
    tick();
    chk({nm, " pulse ends"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int   k;
    logic seen;

    vecs[0]  = '{4'd1,  32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1]  = '{4'd2,  32'd3,          32'd5,          32'hFFFFFFFE,   1'b0};
    vecs[2]  = '{4'd6,  32'd0,          32'h00001234,   32'h12340000,   1'b0};
    vecs[3]  = '{4'd0,  32'h7FFFFFFF,   32'd1,          32'h80000000,   1'b1};
    vecs[4]  = '{4'd5,  32'hFFFFFFFF,   32'd1,          32'd1,          1'b0};
    vecs[5]  = '{4'd9,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    vecs[6]  = '{4'd5,  32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[7]  = '{4'd9,  32'd1,          32'hFFFFFFFF,   32'd1,          1'b0};
    vecs[8]  = '{4'd3,  32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000,   1'b0};
    vecs[9]  = '{4'd4,  32'hF0F0F0F0,   32'hFF00FF00,   32'hFFF0FFF0,   1'b0};
    vecs[10] = '{4'd7,  32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0,   1'b0};
    vecs[11] = '{4'd8,  32'hF0F0F0F0,   32'h0F0F0000,   32'h00000F0F,   1'b0};
    vecs[12] = '{4'd0,  32'h80000000,   32'h80000000,   32'h00000000,   1'b1};
    vecs[13] = '{4'd1,  32'h7FFFFFFF,   32'd1,          32'h80000000,   1'b0};
    vecs[14] = '{4'd6,  32'd0,          32'hABCD5678,   32'h56780000,   1'b0};
    vecs[15] = '{4'd14, 32'd9,          32'd9,          32'd0,          1'b0};

    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    in_valid_8 = 1'b0; op_8 = '0; a_8 = '0; b_8 = '0;
    tick(); tick();
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset hi/lo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("ready after reset", 64'(in_ready), 64'd1);

    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      tick();
      chk($sformatf("vec%0d valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d result", i), 64'(result), 64'(vecs[i].res));
      chk($sformatf("vec%0d ovf", i), 64'(ovf), 64'(vecs[i].ovf));
      chk($sformatf("vec%0d ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("idle no pulse", 64'(out_valid), 64'd0);

    run_md(4'd10, 32'hFFFFFFFD, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFEB, "MULT -3*7");
    do_single(4'd14, 32'd0, 32'd0, 32'hFFFFFFFF, "MFHI");
    do_single(4'd15, 32'd0, 32'd0, 32'hFFFFFFEB, "MFLO");

    in_valid = 1'b1; op = 4'd11; a = 32'd5; b = 32'd6;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid reset hi/lo", {hi, lo}, 64'd0);
    chk("mid reset out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("mid reset ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (k = 0; k < 40; k++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
      tick();
    end
    chk("abandoned mul silent", 64'(seen), 64'd0);

    run_md(4'd12, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, "DIV -7/2");
    run_md(4'd13, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, "DIVU 7/0");
    run_md(4'd12, 32'h80000000, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, 32'd0, 32'h80000000, "DIV min/-1");
    run_md(4'd12, 32'd7, 32'hFFFFFFFE, 32'd0, 32'h80000000, 32'd1, 32'hFFFFFFFD, "DIV 7/-2");
    run_md(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000001, "MULTU max");
    do_single(4'd15, 32'd0, 32'd0, 32'h00000001, "MFLO after MULTU");

    in_valid_8 = 1'b1; op_8 = 4'd11; a_8 = 8'hFF; b_8 = 8'hFF;
    tick();
    in_valid_8 = 1'b0;
    k = 0;
    while (out_valid_8 !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("w8 MULTU latency", 64'(k), 64'd10);
    chk("w8 MULTU hi", 64'(hi_8), 64'hFE);
    chk("w8 MULTU lo", 64'(lo_8), 64'h01);
    in_valid_8 = 1'b1; op_8 = 4'd6; a_8 = 8'h00; b_8 = 8'h0A;
    tick();
    in_valid_8 = 1'b0;
    chk("w8 LUI valid", 64'(out_valid_8), 64'd1);
    chk("w8 LUI result", 64'(result_8), 64'hA0);
    chk("w8 LUI ovf", 64'(ovf_8), 64'd0);
    chk("w8 ready", 64'(in_ready_8), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
